cpu_controller: RTL and testbench
=================================

# cpu_controller

Instruction-cycle sequencer for the 8-bit accumulator CPU. It runs an eight-phase fetch/execute cycle and decodes the 3-bit opcode held in the instruction register. From these it drives the memory, program-counter, instruction-register and accumulator control strobes. It also consumes the ALU zero flag to resolve skip-if-zero. It is the control-side counterpart of the ALU and shares the ALU's opcode encoding.

## Interface
Parameters:
- PHASE_W, 3, phase counter width; fixed at 3, eight phases.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- opcode  input  3  instruction-register opcode field.
- zero  input  1  ALU accumulator-is-zero flag.
- resume  input  1  restart request while halted; level-sampled.
- sel  output  1  memory address mux: 1 selects the PC, 0 selects the IR address field.
- rd  output  1  memory read enable.
- ld_ir  output  1  instruction register load.
- inc_pc  output  1  program counter increment.
- ld_pc  output  1  program counter load from the IR address field.
- ld_ac  output  1  accumulator load from the ALU output.
- data_e  output  1  data bus drive enable, accumulator to memory.
- wr  output  1  memory write strobe.
- halt  output  1  CPU halted indicator.
- phase  output  3  current phase, for debug and bench visibility.

## Operation
- Opcodes: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
- ALUOP = ADD | AND | XOR | LDA.
- Phase register: 3-bit, increments by 1 each clock and wraps from 7 to 0. The only exception is the HLT hold.
- Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- All strobes are combinational decodes of the registered phase, opcode, zero and resume. There is no other state.
- Decode per phase (any strobe not listed is 0):
  - 0: sel=1.
  - 1: sel=1, rd=1.
  - 2: sel=1, rd=1, ld_ir=1.
  - 3: sel=1, rd=1.
  - 4: halt=HLT; inc_pc = !HLT | (HLT & resume).
  - 5: rd=ALUOP.
  - 6: rd=ALUOP; inc_pc = SKZ & zero; data_e=STO.
  - 7: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; data_e=STO; wr=STO.
- HLT hold:
  - In phase 4 with opcode=HLT and resume=0, the phase holds at 4, halt=1 and inc_pc=0.
  - The first cycle with resume=1 gives inc_pc=1 and halt=1 for that cycle, then the phase advances to 5.
  - HLT then completes phases 5–7 with no strobes.
- opcode is consumed from phase 3 onward. The IR is loaded at the end of phase 2, so opcode is stable from phase 3 through phase 7.
- zero is sampled combinationally only in phase 6.
- ld_pc and inc_pc are never both 1 in the same cycle.
- wr is 1 only in phase 7 of STO, with data_e=1 in both phases 6 and 7, so data is driven one cycle before and during the write.
- Unused opcode combinations cannot occur (3-bit encoding is complete). Opcode X/Z drives all opcode-dependent strobes to 0.

## Timing
- Reset: asynchronous. Phase goes to 0 immediately on rst high, independent of clk.
- Outputs during reset: sel=1; rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr and halt = 0; phase=0.
- First clock edge after rst falls moves the phase to 1.
- Instruction latency: 8 cycles per instruction; HLT takes 8 + N cycles, where N is the number of hold cycles.
- Reset mid-instruction, including during an HLT hold or in phase 7 of STO: wr, data_e and halt drop asynchronously. The cycle restarts at phase 0 with no partial write.
- resume asserted outside phase 4/HLT has no effect.
- resume held high across an HLT entry produces zero hold cycles. halt still pulses for one cycle.

## Test plan
- Reset release, opcode=010 (ADD): phase steps 0..7. Check rd=1 in phases 1, 2, 3, 5, 6 and 7; ld_ir=1 in phase 2 only; inc_pc=1 in phase 4; ld_ac=1 in phase 7; sel=1 in phases 0–3; wr=0 throughout.
- opcode=110 (STO): data_e=1 in phases 6 and 7, wr=1 in phase 7 only; rd=0 and ld_ac=0 in phases 5–7.
- opcode=001 (SKZ):
  - zero=1 gives inc_pc=1 in phases 4 and 6 (two increments).
  - zero=0 gives inc_pc=1 in phase 4 only.
- opcode=111 (JMP): ld_pc=1 in phase 7 only, with inc_pc=0 in that cycle.
- opcode=000 (HLT), resume=0 for 5 cycles, then 1:
  - phase=4 and halt=1 for 6 cycles, inc_pc=0 while held.
  - inc_pc=1 on the resume cycle, then phase=5 and halt=0.
- rst pulsed asynchronously mid-phase-7 of STO: wr and data_e go to 0 before the next clk edge, phase=0, sel=1; after release the sequence restarts from phase 0.

Source files
------------

// File: rtl/cpu_controller.sv
// cpu_controller: eight-phase fetch/execute sequencer for the 8-bit accumulator CPU.
// The only state is the phase counter. Every strobe is a combinational decode of
// the phase, the IR opcode, the ALU zero flag and the resume request.
module cpu_controller #(
  parameter int unsigned PHASE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         opcode,
  input  logic               zero,
  input  logic               resume,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               ld_ac,
  output logic               data_e,
  output logic               wr,
  output logic               halt,
  output logic [PHASE_W-1:0] phase
);

  // Opcode encoding shared with the ALU
  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  phase_t phase_q;
  phase_t phase_d;

  logic op_hlt;
  logic op_skz;
  logic op_alu;
  logic op_sto;
  logic op_jmp;
  logic op_known;

  // Opcode flags; an X/Z opcode matches no item, so every flag stays 0
  always_comb begin
    op_hlt   = 1'b0;
    op_skz   = 1'b0;
    op_alu   = 1'b0;
    op_sto   = 1'b0;
    op_jmp   = 1'b0;
    op_known = 1'b0;
    case (opcode)
      OP_HLT: begin op_hlt = 1'b1; op_known = 1'b1; end
      OP_SKZ: begin op_skz = 1'b1; op_known = 1'b1; end
      OP_ADD: begin op_alu = 1'b1; op_known = 1'b1; end
      OP_AND: begin op_alu = 1'b1; op_known = 1'b1; end
      OP_XOR: begin op_alu = 1'b1; op_known = 1'b1; end
      OP_LDA: begin op_alu = 1'b1; op_known = 1'b1; end
      OP_STO: begin op_sto = 1'b1; op_known = 1'b1; end
      OP_JMP: begin op_jmp = 1'b1; op_known = 1'b1; end
      default: ;
    endcase
  end

  // Phase register; reset forces INST_ADDR immediately, independent of clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= INST_ADDR;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Next phase and strobe decode
  always_comb begin
    phase_d = phase_t'(3'(phase_q + 3'd1));
    sel     = 1'b0;
    rd      = 1'b0;
    ld_ir   = 1'b0;
    inc_pc  = 1'b0;
    ld_pc   = 1'b0;
    ld_ac   = 1'b0;
    data_e  = 1'b0;
    wr      = 1'b0;
    halt    = 1'b0;
    case (phase_q)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      IDLE: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      OP_ADDR: begin
        // HLT parks here until resume; the resume cycle itself bumps the PC
        halt   = op_hlt;
        inc_pc = (op_known & ~op_hlt) | (op_hlt & resume);
        if (op_hlt && !resume) begin
          phase_d = OP_ADDR;
        end
      end
      OP_FETCH: begin
        rd = op_alu;
      end
      ALU_OP: begin
        rd     = op_alu;
        inc_pc = op_skz & zero;
        data_e = op_sto;
      end
      STORE: begin
        rd     = op_alu;
        ld_ac  = op_alu;
        ld_pc  = op_jmp;
        data_e = op_sto;
        wr     = op_sto;
      end
      default: ;
    endcase
  end

  assign phase = PHASE_W'(phase_q);

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed bench with a phase/decode reference model checked
// every cycle, plus hand-computed per-phase expectations for each instruction.
module tb_cpu_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       resume;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
  logic [2:0] phase;

  int n_cmp;
  int n_fail;
  int m_phase;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  cpu_controller #(.PHASE_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .resume(resume),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .data_e(data_e), .wr(wr), .halt(halt), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference outputs {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,data_e,wr,halt,phase}
  function automatic logic [11:0] model_out(input int ph, input logic [2:0] op,
                                            input logic z, input logic r);
    logic aluop;
    logic [8:0] s;
    aluop = (op inside {3'b010, 3'b011, 3'b100, 3'b101});
    s[8] = (ph <= 3);
    s[7] = (ph inside {1, 2, 3}) || (ph >= 5 && aluop);
    s[6] = (ph == 2);
    s[5] = (ph == 4 && (op != HLT || r)) || (ph == 6 && op == SKZ && z);
    s[4] = (ph == 7 && op == JMP);
    s[3] = (ph == 7 && aluop);
    s[2] = (ph >= 6 && op == STO);
    s[1] = (ph == 7 && op == STO);
    s[0] = (ph == 4 && op == HLT);
    return {s, 3'(ph)};
  endfunction

  // Model phase: counts modulo 8, parks at 4 on HLT without resume
  always @(posedge clk or posedge rst) begin
    if (rst) m_phase <= 0;
    else if (m_phase == 4 && opcode == HLT && !resume) m_phase <= 4;
    else m_phase <= (m_phase + 1) % 8;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [11:0] act, exp;
    act = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, phase};
    exp = model_out(m_phase, opcode, zero, resume);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model t=%0t act=%h exp=%h", $time, act, exp);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full instruction from phase 0; masks hold bit k = strobe in phase k
  task automatic run_instr(input logic [2:0] op, input logic z,
                           input logic [7:0] m_rd, input logic [7:0] m_inc,
                           input logic [7:0] m_ldpc, input logic [7:0] m_ldac,
                           input logic [7:0] m_de, input logic [7:0] m_wr);
    logic [7:0] m_sel, m_ldir;
    m_sel  = 8'b0000_1111;
    m_ldir = 8'b0000_0100;
    opcode = op;
    zero   = z;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("phase",  8'(phase),  8'(k));
      chk("sel",    8'(sel),    8'(m_sel[k]));
      chk("rd",     8'(rd),     8'(m_rd[k]));
      chk("ld_ir",  8'(ld_ir),  8'(m_ldir[k]));
      chk("inc_pc", 8'(inc_pc), 8'(m_inc[k]));
      chk("ld_pc",  8'(ld_pc),  8'(m_ldpc[k]));
      chk("ld_ac",  8'(ld_ac),  8'(m_ldac[k]));
      chk("data_e", 8'(data_e), 8'(m_de[k]));
      chk("wr",     8'(wr),     8'(m_wr[k]));
      chk("halt",   8'(halt),   8'h00);
      next_cycle();
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; opcode = ADD; zero = 1'b0; resume = 1'b0;
    @(negedge clk);
    chk("rst_phase", 8'(phase), 8'h00);
    chk("rst_sel",   8'(sel),   8'h01);
    chk("rst_rd",    8'(rd),    8'h00);
    chk("rst_halt",  8'(halt),  8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADD, ADD with stray resume, XOR, STO, SKZ taken/not taken, JMP
    run_instr(ADD, 1'b0, 8'b1110_1110, 8'b0001_0000, 8'h00, 8'h80, 8'h00, 8'h00);
    resume = 1'b1;
    run_instr(ADD, 1'b1, 8'b1110_1110, 8'b0001_0000, 8'h00, 8'h80, 8'h00, 8'h00);
    resume = 1'b0;
    run_instr(XOR, 1'b0, 8'b1110_1110, 8'b0001_0000, 8'h00, 8'h80, 8'h00, 8'h00);
    run_instr(STO, 1'b0, 8'b0000_1110, 8'b0001_0000, 8'h00, 8'h00, 8'hC0, 8'h80);
    run_instr(SKZ, 1'b1, 8'b0000_1110, 8'b0101_0000, 8'h00, 8'h00, 8'h00, 8'h00);
    run_instr(SKZ, 1'b0, 8'b0000_1110, 8'b0001_0000, 8'h00, 8'h00, 8'h00, 8'h00);
    run_instr(JMP, 1'b1, 8'b0000_1110, 8'b0001_0000, 8'h80, 8'h00, 8'h00, 8'h00);

    // HLT: five held cycles, then resume
    opcode = HLT; zero = 1'b0; resume = 1'b0;
    repeat (4) next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_phase", 8'(phase), 8'h04);
      chk("hold_halt",  8'(halt),  8'h01);
      chk("hold_inc",   8'(inc_pc), 8'h00);
      next_cycle();
    end
    resume = 1'b1;
    @(negedge clk);
    chk("res_phase", 8'(phase), 8'h04);
    chk("res_halt",  8'(halt),  8'h01);
    chk("res_inc",   8'(inc_pc), 8'h01);
    next_cycle();
    resume = 1'b0;
    for (int k = 5; k < 8; k++) begin
      @(negedge clk);
      chk("hlt_tail_phase", 8'(phase), 8'(k));
      chk("hlt_tail_strb",  8'({rd, inc_pc, ld_pc, ld_ac, data_e, wr, halt}), 8'h00);
      next_cycle();
    end

    // HLT entered with resume already high: no hold, single halt pulse
    opcode = HLT; resume = 1'b1;
    repeat (4) next_cycle();
    @(negedge clk);
    chk("hr_phase", 8'(phase), 8'h04);
    chk("hr_halt",  8'(halt),  8'h01);
    chk("hr_inc",   8'(inc_pc), 8'h01);
    next_cycle();
    @(negedge clk);
    chk("hr_next", 8'(phase), 8'h05);
    chk("hr_halt0", 8'(halt), 8'h00);
    repeat (3) next_cycle();
    resume = 1'b0;

    // Async reset in phase 7 of STO
    opcode = STO;
    repeat (7) next_cycle();
    @(negedge clk);
    chk("sto7_wr", 8'(wr),     8'h01);
    chk("sto7_de", 8'(data_e), 8'h01);
    #1 rst = 1'b1;
    #1;
    chk("ar_wr",    8'(wr),     8'h00);
    chk("ar_de",    8'(data_e), 8'h00);
    chk("ar_phase", 8'(phase),  8'h00);
    chk("ar_sel",   8'(sel),    8'h01);
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(ADD, 1'b0, 8'b1110_1110, 8'b0001_0000, 8'h00, 8'h80, 8'h00, 8'h00);

    // Async reset during an HLT hold
    opcode = HLT; resume = 1'b0;
    repeat (6) next_cycle();
    @(negedge clk);
    chk("hh_halt", 8'(halt), 8'h01);
    #1 rst = 1'b1;
    #1;
    chk("ahr_halt",  8'(halt),  8'h00);
    chk("ahr_phase", 8'(phase), 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(JMP, 1'b0, 8'b0000_1110, 8'b0001_0000, 8'h80, 8'h00, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
